// File: rtl/debounce_multi.sv
// Multi-channel switch/encoder debouncer: per-channel synchroniser, lockout (MODE 0) or
// stable-confirm (MODE 1) filter, registered rise/fall strobes. DEBOUNCE_GLITCH_CNT_EN adds a glitch counter.
module debounce_multi #(
  parameter int   CHANNELS    = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   HOLD_CYCLES = 65535,
  parameter int   MODE        = 0,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw_in,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                glitch_clr,
  output logic [15:0]         glitch_cnt,
`endif
  output logic [CHANNELS-1:0] sw_out,
  output logic [CHANNELS-1:0] sw_rise,
  output logic [CHANNELS-1:0] sw_fall,
  output logic [CHANNELS-1:0] busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // r_sync[0] captures the raw pin; r_sync[SYNC_STAGES-1] is the synchronised level.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  w_s;

  logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;
  logic [CHANNELS-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [CHANNELS-1:0]            r_out;
  logic [CHANNELS-1:0]            w_out_nxt;
  logic [CHANNELS-1:0]            r_rise;
  logic [CHANNELS-1:0]            w_rise_nxt;
  logic [CHANNELS-1:0]            r_fall;
  logic [CHANNELS-1:0]            w_fall_nxt;
  logic [CHANNELS-1:0]            w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {(SYNC_STAGES * CHANNELS){RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_out_nxt  = r_out;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (MODE == 0) begin
        // Lockout: accept a new level at once, then ignore the pin for HOLD_CYCLES.
        if (r_cnt[i] != CNT_ZERO) begin
          w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
        end else if (w_s[i] != r_out[i]) begin
          w_out_nxt[i]  = w_s[i];
          w_rise_nxt[i] = w_s[i];
          w_fall_nxt[i] = ~w_s[i];
          w_cnt_nxt[i]  = HOLD_VAL;
        end
      end else begin
        // Stable-confirm: the pin must differ from sw_out for HOLD_CYCLES consecutive cycles.
        if (w_s[i] == r_out[i]) begin
          w_cnt_nxt[i] = CNT_ZERO;
        end else if (r_cnt[i] == HOLD_LAST) begin
          w_out_nxt[i]  = w_s[i];
          w_rise_nxt[i] = w_s[i];
          w_fall_nxt[i] = ~w_s[i];
          w_cnt_nxt[i]  = CNT_ZERO;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_out  <= {CHANNELS{RESET_LEVEL}};
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_out_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_busy[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  assign sw_out  = r_out;
  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
  assign busy    = w_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam int EV_W = $clog2(CHANNELS + 1);
  localparam int GS_W = ((EV_W > 16) ? EV_W : 16) + 1;

  logic [CHANNELS-1:0] r_s_prev;
  logic [CHANNELS-1:0] w_glitch_ev;
  logic [EV_W-1:0]     w_ev_sum;
  logic [GS_W-1:0]     w_glitch_sum;
  logic [15:0]         r_glitch;

  // A glitch is pin activity the filter rejected while a channel's counter was running.
  always_comb begin
    w_glitch_ev = '0;
    w_ev_sum    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (MODE == 0) begin
        w_glitch_ev[i] = (w_s[i] != r_s_prev[i]) && (r_cnt[i] != CNT_ZERO);
      end else begin
        w_glitch_ev[i] = (w_s[i] == r_out[i]) && (r_cnt[i] != CNT_ZERO);
      end
      w_ev_sum = w_ev_sum + EV_W'(w_glitch_ev[i]);
    end
    w_glitch_sum = GS_W'(r_glitch) + GS_W'(w_ev_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_prev <= {CHANNELS{RESET_LEVEL}};
      r_glitch <= '0;
    end else begin
      r_s_prev <= w_s;
      if (glitch_clr) begin
        r_glitch <= '0;
      end else if (w_glitch_sum > GS_W'(16'hFFFF)) begin
        r_glitch <= 16'hFFFF;
      end else begin
        r_glitch <= w_glitch_sum[15:0];
      end
    end
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: four instances (MODE 0/1 x HOLD 8/1) on shared pins, an
// event-level model compared every cycle, plus directed literal checks.
module tb_debounce_multi;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int ND = 4;
  localparam int BIG = 1 << 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] sw_in = '0;

  logic [CH-1:0] d_out [ND];
  logic [CH-1:0] d_rise[ND];
  logic [CH-1:0] d_fall[ND];
  logic [CH-1:0] d_busy[ND];
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic          glitch_clr = 1'b0;
  logic [15:0]   d_glitch[ND];
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Instance g: MODE = g%2, HOLD_CYCLES = 8 for g<2 else 1.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    debounce_multi #(
      .CHANNELS   (CH),
      .SYNC_STAGES(SS),
      .HOLD_CYCLES((g < 2) ? 8 : 1),
      .MODE       (g % 2),
      .RESET_LEVEL(1'b0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_clr(glitch_clr),
      .glitch_cnt(d_glitch[g]),
`endif
      .sw_out    (d_out[g]),
      .sw_rise   (d_rise[g]),
      .sw_fall   (d_fall[g]),
      .busy      (d_busy[g])
    );
  end

  function automatic int hold_of(input int g);
    return (g < 2) ? 8 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: pin history queue, per-channel "cycles since commit" (MODE 0) and
  // "consecutive mismatch cycles" (MODE 1).
  logic [CH-1:0] m_pipe[SS];
  logic [CH-1:0] m_prev_s;
  int            m_since [ND][CH];
  int            m_streak[ND][CH];
  logic [CH-1:0] m_out [ND];
  logic [CH-1:0] m_rise[ND];
  logic [CH-1:0] m_fall[ND];
  logic [CH-1:0] m_busy[ND];
  int            m_glitch[ND];
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [CH-1:0] s;
    int ev;
    int h;
    bit locked;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      m_prev_s = '0;
      for (int g = 0; g < ND; g++) begin
        m_out[g] = '0; m_rise[g] = '0; m_fall[g] = '0; m_busy[g] = '0;
        m_glitch[g] = 0;
        for (int i = 0; i < CH; i++) begin
          m_since[g][i] = BIG;
          m_streak[g][i] = 0;
        end
      end
      m_valid = 1'b1;
    end else begin
      s = m_pipe[SS-1];
      for (int g = 0; g < ND; g++) begin
        ev = 0;
        h = hold_of(g);
        m_rise[g] = '0;
        m_fall[g] = '0;
        for (int i = 0; i < CH; i++) begin
          if (g % 2 == 0) begin
            locked = (m_since[g][i] < h);
            if (locked && s[i] != m_prev_s[i]) ev++;
            if (!locked && s[i] != m_out[g][i]) begin
              m_out[g][i] = s[i];
              if (s[i]) m_rise[g][i] = 1'b1; else m_fall[g][i] = 1'b1;
              m_since[g][i] = 0;
            end else if (m_since[g][i] < BIG) begin
              m_since[g][i]++;
            end
            m_busy[g][i] = (m_since[g][i] < h);
          end else begin
            if (s[i] == m_out[g][i]) begin
              if (m_streak[g][i] != 0) ev++;
              m_streak[g][i] = 0;
            end else if (m_streak[g][i] == h - 1) begin
              m_out[g][i] = s[i];
              if (s[i]) m_rise[g][i] = 1'b1; else m_fall[g][i] = 1'b1;
              m_streak[g][i] = 0;
            end else begin
              m_streak[g][i]++;
            end
            m_busy[g][i] = (m_streak[g][i] != 0);
          end
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        if (glitch_clr) m_glitch[g] = 0;
        else if (m_glitch[g] + ev > 65535) m_glitch[g] = 65535;
        else m_glitch[g] = m_glitch[g] + ev;
`endif
      end
      m_prev_s = s;
      for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = sw_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int g = 0; g < ND; g++) begin
        chk($sformatf("d%0d_out", g),  32'(d_out[g]),  32'(m_out[g]));
        chk($sformatf("d%0d_rise", g), 32'(d_rise[g]), 32'(m_rise[g]));
        chk($sformatf("d%0d_fall", g), 32'(d_fall[g]), 32'(m_fall[g]));
        chk($sformatf("d%0d_busy", g), 32'(d_busy[g]), 32'(m_busy[g]));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk($sformatf("d%0d_glitch", g), 32'(d_glitch[g]), 32'(m_glitch[g]));
`endif
      end
    end
  end

  initial begin
    int n_r0;
    int n_s1;

    // Reset with both pins high, then release.
    rst = 1'b1; sw_in = 2'b11;
    tick();
    chk("rst_out", 32'(d_out[0]), 32'h0);
    chk("rst_busy", 32'(d_busy[0]), 32'h0);
    chk("rst_rise", 32'(d_rise[0]), 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 2)  chk("t1_out_c2", 32'(d_out[0]), 32'h0);
      if (c == 3)  chk("t1_out_c3", 32'(d_out[0]), 32'h3);
      if (c == 3)  chk("t1_rise_c3", 32'(d_rise[0]), 32'h3);
      if (c == 4)  chk("t1_rise_c4", 32'(d_rise[0]), 32'h0);
      if (c == 10) chk("t1_busy_c10", 32'(d_busy[0]), 32'h3);
      if (c == 11) chk("t1_busy_c11", 32'(d_busy[0]), 32'h0);
      if (c == 9)  chk("t1_m1_rise_c9", 32'(d_rise[1]), 32'h0);
      if (c == 10) chk("t1_m1_rise_c10", 32'(d_rise[1]), 32'h3);
    end

    // MODE 0 bounce on ch0: 0-1-0-1 then held high.
    rst = 1'b1; sw_in = 2'b00; tick(); rst = 1'b0;
    repeat (4) tick();
    n_r0 = 0; n_s1 = 0;
    for (int c = 1; c <= 25; c++) begin
      sw_in = (c == 2) ? 2'b00 : 2'b01;
      tick();
      if (d_rise[0][0]) n_r0++;
      if (d_rise[0][1] || d_fall[0][1] || d_fall[0][0]) n_s1++;
      if (c == 3) chk("t2_rise_c3", 32'(d_rise[0]), 32'h1);
    end
    chk("t2_rise_count", 32'(n_r0), 32'd1);
    chk("t2_other_strobes", 32'(n_s1), 32'd0);
    chk("t2_out", 32'(d_out[0]), 32'h1);

    // MODE 0: ch1 rises, then falls inside the lockout and stays low.
    for (int c = 1; c <= 25; c++) begin
      sw_in = (c <= 4) ? 2'b11 : 2'b01;
      tick();
      if (c == 3)  chk("t3_rise_c3", 32'(d_rise[0]), 32'h2);
      if (c == 11) chk("t3_fall_c11", 32'(d_fall[0]), 32'h0);
      if (c == 11) chk("t3_busy_c11", 32'(d_busy[0]), 32'h0);
      if (c == 12) chk("t3_fall_c12", 32'(d_fall[0]), 32'h2);
    end
    chk("t3_out", 32'(d_out[0]), 32'h1);

    // MODE 1: 5-cycle pulse rejected, 12-cycle pulse accepted.
    rst = 1'b1; sw_in = 2'b00; tick(); rst = 1'b0;
    repeat (4) tick();
    n_r0 = 0;
    for (int c = 1; c <= 20; c++) begin
      sw_in = (c <= 5) ? 2'b01 : 2'b00;
      tick();
      if (d_rise[1] != 2'b00) n_r0++;
    end
    chk("t4_short_rise", 32'(n_r0), 32'd0);
    chk("t4_short_out", 32'(d_out[1]), 32'h0);
    for (int c = 1; c <= 30; c++) begin
      sw_in = (c <= 12) ? 2'b01 : 2'b00;
      tick();
      if (c == 3)  chk("t4_h1_rise_c3", 32'(d_rise[3]), 32'h1);
      if (c == 9)  chk("t4_rise_c9", 32'(d_rise[1]), 32'h0);
      if (c == 10) chk("t4_rise_c10", 32'(d_rise[1]), 32'h1);
      if (c == 10) chk("t4_out_c10", 32'(d_out[1]), 32'h1);
    end

    // Opposite toggles on the same cycle, then reset in mid-lockout.
    rst = 1'b1; sw_in = 2'b10; tick(); rst = 1'b0;
    repeat (25) tick();
    sw_in = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 3) begin
        chk("t5_rise_c3", 32'(d_rise[0]), 32'h1);
        chk("t5_fall_c3", 32'(d_fall[0]), 32'h2);
        chk("t5_h1_rise_c3", 32'(d_rise[2]), 32'h1);
        chk("t5_h1_fall_c3", 32'(d_fall[2]), 32'h2);
      end
    end
    chk("t5_busy_pre_rst", 32'(d_busy[0]), 32'h3);
    rst = 1'b1;
    tick();
    chk("t5_rst_out", 32'(d_out[0]), 32'h0);
    chk("t5_rst_rise", 32'(d_rise[0]), 32'h0);
    chk("t5_rst_fall", 32'(d_fall[0]), 32'h0);
    chk("t5_rst_busy", 32'(d_busy[0]), 32'h0);
    rst = 1'b0;
    repeat (15) tick();

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Three short pulses on both channels.
    rst = 1'b1; sw_in = 2'b00; tick(); rst = 1'b0;
    repeat (5) tick();
    for (int p = 0; p < 3; p++) begin
      sw_in = 2'b11; repeat (2) tick();
      sw_in = 2'b00; repeat (4) tick();
    end
    repeat (10) tick();
    chk("g_six", 32'(d_glitch[1]), 32'd6);

    // Clear held across the event cycle of another pulse.
    glitch_clr = 1'b1;
    sw_in = 2'b11; repeat (2) tick();
    sw_in = 2'b00; repeat (8) tick();
    glitch_clr = 1'b0;
    tick();
    chk("g_clr", 32'(d_glitch[1]), 32'd0);

    // 70000 events: one per channel every two cycles.
    for (int k = 0; k < 35000; k++) begin
      sw_in = 2'b11; tick();
      sw_in = 2'b00; tick();
    end
    repeat (5) tick();
    chk("g_sat", 32'(d_glitch[1]), 32'd65535);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-pin encoder debouncer.
- Synchronises N asynchronous switch or encoder pins and filters contact bounce per channel.
- Emits a clean level plus one-cycle rise/fall strobes for the quadrature decoder and the push-button logic.
- Two filter modes, chosen at elaboration: immediate-accept with lockout, or accept-after-stable.

Parameters:
- CHANNELS, 2: number of independent input pins (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- HOLD_CYCLES, 65535: lockout length (MODE 0) or required stable time (MODE 1), in clk cycles (>=1).
- MODE, 0: 0 = lockout, 1 = stable-confirm.
- RESET_LEVEL, 0: reset value of synchroniser flops and sw_out (1 bit, same for all channels).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- sw_in, input, CHANNELS: raw asynchronous pins.
- sw_out, output, CHANNELS: debounced level.
- sw_rise, output, CHANNELS: one-cycle pulse on debounced 0->1.
- sw_fall, output, CHANNELS: one-cycle pulse on debounced 1->0.
- busy, output, CHANNELS: per-channel counter non-zero.

Behaviour:
- Clocking and reset:
  - One clock, rst synchronous active-high.
  - On rst: all synchroniser flops and sw_out = RESET_LEVEL; sw_rise = sw_fall = 0; counters = 0; busy = 0.
  - rst mid-lockout or mid-confirm aborts the operation; no strobe is issued.
- Per channel i, fully independent; no shared state except the optional counter.
- Synchroniser: s[i] = output of the last of SYNC_STAGES flops.
- Counter width: CNT_W = $clog2(HOLD_CYCLES+1), local.
- MODE 0 (lockout):
  - cnt==0 and s!=sw_out: sw_out<=s; matching strobe=1 this edge; cnt<=HOLD_CYCLES.
  - cnt!=0: cnt<=cnt-1; sw_out holds; strobes 0.
  - A level still differing when cnt reaches 0 is committed on the next edge, so no edge is lost.
  - Latency sw_in edge -> sw_out/strobe: SYNC_STAGES+1 cycles.
- MODE 1 (stable-confirm):
  - s==sw_out: cnt<=0.
  - s!=sw_out and cnt==HOLD_CYCLES-1: sw_out<=s; strobe=1; cnt<=0.
  - s!=sw_out otherwise: cnt<=cnt+1.
  - Latency: SYNC_STAGES+HOLD_CYCLES cycles. Pulses shorter than HOLD_CYCLES never reach sw_out.
- Strobes:
  - Registered and exactly one cycle wide.
  - sw_rise[i] and sw_fall[i] are never both 1.
  - A strobe is asserted only in the cycle sw_out[i] changes.
- busy[i] = (cnt[i]!=0), combinational from the counter.
- HOLD_CYCLES=1: MODE 0 locks for one cycle; MODE 1 commits after one cycle of mismatch.
- Counters never wrap. The MODE 0 decrement stops at 0; the MODE 1 increment is bounded by the commit.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds input glitch_clr (1 bit) and output glitch_cnt (16 bits).
  - Glitch event per channel:
    - MODE 0: s[i] changes while cnt[i]!=0.
    - MODE 1: s[i] returns to sw_out[i] while cnt[i]!=0.
  - Each cycle, glitch_cnt += number of channels with an event; saturates at 16'hFFFF.
  - glitch_clr=1 loads 0 and discards that cycle's events (clear has priority).
  - rst clears to 0.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Test Plan:
- Reset, MODE 0, CHANNELS=2, HOLD_CYCLES=8, sw_in=2'b11 held: after rst drops, sw_out=2'b11 at cycle 3; sw_rise=2'b11 for exactly 1 cycle; busy high 8 cycles.
- MODE 0, ch0 bounces 0-1-0-1 at 1-cycle spacing, then stays 1: one sw_rise[0] at SYNC_STAGES+1; then, once lockout ends (s at its final 1, equal to sw_out), no further strobe; ch1 untouched.
- MODE 0, input falls during lockout and stays low: sw_fall fires on the cycle after cnt hits 0, with no lost edge.
- MODE 1, HOLD_CYCLES=8: a 5-cycle high pulse gives no strobe and sw_out stays 0. A 12-cycle high gives sw_rise at cycle SYNC_STAGES+8.
- Both channels toggle on the same cycle in opposite directions: sw_rise[0] and sw_fall[1] in the same cycle. rst asserted mid-lockout: outputs return to RESET_LEVEL next edge with no strobe.
- DEBOUNCE_GLITCH_CNT_EN, MODE 1: 3 short pulses on each of 2 channels give glitch_cnt=6. With glitch_clr asserted on an event cycle, glitch_cnt=0. Force 70000 events: glitch_cnt saturates at 65535.
